move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 The block SHALL have parameter DEB_TICKS, default 4, giving the number of tick pulses a synchronized button must differ from its debounced state before that state flips.
REQ-002 The block SHALL have parameter DONE_TIMEOUT, default 1023, giving the maximum clk cycles spent in WAIT_DONE before abort.
REQ-003 clk  in  1  system clock; all state is on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 tick  in  1  single-cycle debounce sample enable (derived from the shared clock divider).
REQ-006 btn_u, btn_d, btn_l, btn_r  in  1 each  raw, asynchronous pushbuttons, active-high.
REQ-007 move_valid  out  1  move command valid.
REQ-008 move_dir  out  2  direction code: UP=0, DOWN=1, LEFT=2, RIGHT=3.
REQ-009 move_ready  in  1  board datapath accepts the command.
REQ-010 board_done  in  1  single-cycle pulse: board slide/merge/spawn complete.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 move_count  out  16  count of accepted moves.
REQ-013 timeout_err  out  1  sticky: board_done was missed.

Function
REQ-014 Each button SHALL pass through a two-flop synchronizer before debounce.
REQ-015 Debounce per button: on tick, if synced != stable, counter increments; if equal, counter clears; when counter reaches DEB_TICKS, stable takes synced and counter clears; without tick, counter holds.
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE and RELEASE.
REQ-017 IDLE: if any stable button is high, the FSM SHALL latch move_dir with fixed priority U>D>L>R and enter ISSUE on the next edge.
REQ-018 ISSUE: move_valid=1 and move_dir SHALL stay constant regardless of button activity; on move_valid&&move_ready, the FSM enters WAIT_DONE and move_count increments.
REQ-019 move_valid SHALL be asserted only in ISSUE and SHALL deassert on the cycle after the handshake.
REQ-020 WAIT_DONE: the timeout counter clears on entry and increments each clk; board_done moves the FSM to RELEASE.
REQ-021 WAIT_DONE: when the timeout counter reaches DONE_TIMEOUT without board_done, the block SHALL set timeout_err and enter RELEASE.
REQ-022 If board_done and the timeout coincide, board_done wins and timeout_err is not set.
REQ-023 RELEASE: the FSM SHALL return to IDLE only when all four stable buttons are low; a held button never issues a second move.
REQ-024 board_done outside WAIT_DONE SHALL be ignored.
REQ-025 move_count SHALL wrap from 0xFFFF to 0x0000.
REQ-026 Latency: move_valid rises exactly one clk after the first stable rise while in IDLE.

Reset
REQ-027 While rst is high: state=IDLE; move_valid=0; move_dir=0; busy=0; move_count=0; timeout_err=0; all synchronizers, stable bits and counters are 0.
REQ-028 rst asserted mid-ISSUE SHALL drop move_valid asynchronously, with no count increment.
REQ-029 timeout_err SHALL clear only on rst.

Structure
REQ-030 The direction codes and FSM state encoding SHALL live in shared package game_pkg.
REQ-031 Per-button synchronization and debounce SHALL be sub-module btn_debounce, instantiated four times with DEB_TICKS passed through.

Verification (tick tied high, DEB_TICKS=4, DONE_TIMEOUT=20)
REQ-032 btn_l held 10 cycles, move_ready=1 -> single move_valid pulse, move_dir=2 at cycle 2+4+1; move_count=1.
REQ-033 btn_u and btn_r pressed the same cycle -> move_dir=0; exactly one move.
REQ-034 3-cycle glitch on btn_d -> no move_valid.
REQ-035 move_ready held 0 for 5 cycles -> move_valid and move_dir stable; count increments once on ready.
REQ-036 no board_done -> timeout_err=1 after 20 WAIT_DONE cycles; button held -> stays RELEASE until release.
REQ-037 rst mid-ISSUE -> move_valid=0 immediately, move_count unchanged at 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared direction codes and FSM state encoding for the move sequencer.
package game_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_RELEASE   = 2'd3;

    // btn is {right, left, down, up}; up has highest priority.
    function automatic logic [1:0] pick_dir(input logic [3:0] btn);
        if (btn[0])      return DIR_UP;
        else if (btn[1]) return DIR_DOWN;
        else if (btn[2]) return DIR_LEFT;
        else             return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a tick-sampled debounce counter.
module btn_debounce #(
    parameter int DEB_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic stable
);
    localparam int CW = $clog2(DEB_TICKS + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick) begin
            if (sync2_q != stable_q) begin
                // The increment that would reach DEB_TICKS flips the state instead.
                if (cnt_q == CW'(DEB_TICKS - 1)) begin
                    stable_d = sync2_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/move_sequencer.sv
// Turns debounced pushbuttons into one move command per press and tracks
// completion of the board update, with a sticky timeout on a missed done.
module move_sequencer
    import game_pkg::*;
#(
    parameter int DEB_TICKS    = 4,
    parameter int DONE_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    output logic        move_valid,
    output logic [1:0]  move_dir,
    input  logic        move_ready,
    input  logic        board_done,
    output logic        busy,
    output logic [15:0] move_count,
    output logic        timeout_err
);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    logic [3:0]    btn_raw;
    logic [3:0]    btn_stable;
    logic [1:0]    state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [15:0]   count_q, count_d;
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;

    assign btn_raw = {btn_r, btn_l, btn_d, btn_u};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .btn_in (btn_raw[i]),
            .stable (btn_stable[i])
        );
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        count_d = count_q;
        to_d    = to_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|btn_stable) begin
                    dir_d   = pick_dir(btn_stable);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (move_ready) begin
                    count_d = count_q + 16'd1;
                    to_d    = '0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // Bounds the stay to DONE_TIMEOUT cycles; a coincident done wins.
                if (board_done) begin
                    state_d = ST_RELEASE;
                end else if (to_q == TW'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (btn_stable == 4'b0000) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            count_q <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign move_valid  = (state_q == ST_ISSUE);
    assign move_dir    = dir_q;
    assign busy        = (state_q != ST_IDLE);
    assign move_count  = count_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a scoreboard of expected moves.
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        btn_u, btn_d, btn_l, btn_r;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        board_done;
    logic        busy;
    logic [15:0] move_count;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int valid_cycles = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    move_sequencer #(.DEB_TICKS(4), .DONE_TIMEOUT(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn_u       (btn_u),
        .btn_d       (btn_d),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_ready  (move_ready),
        .board_done  (board_done),
        .busy        (busy),
        .move_count  (move_count),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every handshake pops the expected direction.
    always @(negedge clk) begin
        if (!rst && move_valid === 1'b1) valid_cycles++;
        if (!rst && move_valid === 1'b1 && move_ready === 1'b1) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_move", 32'(move_dir), 32'hdead);
            end else begin
                chk("move_dir_sb", 32'(move_dir), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (move_valid === 1'b1) break;
            step(1);
        end
        chk(tag, 32'(move_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) break;
            step(1);
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulse_done();
        board_done = 1'b1;
        step(1);
        board_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1;
        btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
        move_ready = 1'b1; board_done = 1'b0;
        step(3);
        chk("rst_valid", 32'(move_valid), 32'd0);
        chk("rst_dir",   32'(move_dir),   32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_count", 32'(move_count), 32'd0);
        chk("rst_err",   32'(timeout_err), 32'd0);
        rst = 1'b0;
        step(2);

        // Left held 10 cycles: valid exactly at edge 7 after press.
        btn_l = 1'b1; exp_q.push_back(2'd2);
        step(6);
        chk("l_lat_pre", 32'(move_valid), 32'd0);
        step(1);
        chk("l_lat_valid", 32'(move_valid), 32'd1);
        chk("l_lat_dir",   32'(move_dir),   32'd2);
        step(1);
        chk("l_valid_drop", 32'(move_valid), 32'd0);
        chk("l_count", 32'(move_count), 32'd1);
        chk("l_busy",  32'(busy), 32'd1);
        step(1);
        pulse_done();
        btn_l = 1'b0;
        step(2);
        chk("l_release_busy", 32'(busy), 32'd1);
        wait_idle("l_idle");
        chk("l_hs", 32'(hs_cnt), 32'd1);

        // Up and right together: up wins, one move.
        btn_u = 1'b1; btn_r = 1'b1; exp_q.push_back(2'd0);
        wait_valid("ur_valid");
        chk("ur_dir", 32'(move_dir), 32'd0);
        step(2);
        pulse_done();
        step(5);
        chk("ur_no_second", 32'(move_valid), 32'd0);
        btn_u = 1'b0; btn_r = 1'b0;
        wait_idle("ur_idle");
        chk("ur_hs", 32'(hs_cnt), 32'd2);
        chk("ur_count", 32'(move_count), 32'd2);

        // Three-cycle glitch on down is filtered.
        begin
            int vc;
            vc = valid_cycles;
            btn_d = 1'b1;
            step(3);
            btn_d = 1'b0;
            step(15);
            chk("glitch_valid", 32'(valid_cycles - vc), 32'd0);
            chk("glitch_busy", 32'(busy), 32'd0);
        end

        // Ready held low: command stable, count waits for handshake.
        move_ready = 1'b0;
        btn_r = 1'b1; exp_q.push_back(2'd3);
        wait_valid("stall_valid");
        btn_u = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_hold_valid", 32'(move_valid), 32'd1);
            chk("stall_hold_dir",   32'(move_dir),   32'd3);
            chk("stall_hold_count", 32'(move_count), 32'd2);
            btn_u = ~btn_u;
        end
        btn_u = 1'b0;
        move_ready = 1'b1;
        step(1);
        chk("stall_drop", 32'(move_valid), 32'd0);
        chk("stall_count", 32'(move_count), 32'd3);
        pulse_done();
        btn_r = 1'b0;
        wait_idle("stall_idle");

        // No done: timeout after 20 WAIT_DONE cycles, held button keeps RELEASE.
        btn_u = 1'b1; exp_q.push_back(2'd0);
        wait_valid("to_valid");
        step(1);
        chk("to_count", 32'(move_count), 32'd4);
        step(19);
        chk("to_err_early", 32'(timeout_err), 32'd0);
        step(1);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        step(5);
        chk("to_hold_busy", 32'(busy), 32'd1);
        chk("to_hold_novalid", 32'(move_valid), 32'd0);
        btn_u = 1'b0;
        wait_idle("to_idle");
        pulse_done();
        step(2);
        chk("done_ignored", 32'(busy), 32'd0);
        chk("err_sticky", 32'(timeout_err), 32'd1);

        // Reset clears everything, then reset mid-ISSUE drops valid at once.
        rst = 1'b1;
        step(1);
        chk("rst2_err", 32'(timeout_err), 32'd0);
        chk("rst2_count", 32'(move_count), 32'd0);
        rst = 1'b0;
        move_ready = 1'b0;
        btn_l = 1'b1;
        wait_valid("ri_valid");
        #2;
        rst = 1'b1;
        #1;
        chk("ri_async_drop", 32'(move_valid), 32'd0);
        chk("ri_count", 32'(move_count), 32'd0);
        btn_l = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);
        chk("ri_idle", 32'(busy), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("hs_total", 32'(hs_cnt), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
